// File: rtl/inst_fetch.sv
// Fetch initiator: owns the PC, drives the ROM, queues {inst, pc} pairs for decode.
// Latency: word fetched in cycle N is presented on id_* in cycle N+1 (registered queue).
// Backpressure: fetch stalls when the queue is full and not popping; redirect flushes.
module inst_fetch #(
    parameter int                  ADDR_W   = 32,
    parameter int                  INST_W   = 64,
    parameter logic [ADDR_W-1:0]   RESET_PC = '0,
    parameter int                  DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic              rom_ce,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [INST_W-1:0] rom_inst,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [INST_W-1:0] id_inst,
    output logic [ADDR_W-1:0] id_pc,
    output logic [31:0]       fetch_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [ADDR_W-1:0] pc;
    } entry_t;

    entry_t             q_mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic [ADDR_W-1:0]  pc;
    logic               en_q;
    logic               pop;
    logic               can_push;
    entry_t             head;

    assign id_valid = (count != '0);
    assign pop      = id_valid & id_ready;
    assign can_push = (count < CNT_W'(DEPTH)) | pop;
    assign rom_ce   = en_q & ~redirect & can_push;
    assign rom_addr = pc;

    // Head is masked so decode never sees stale storage while the queue is empty.
    assign head    = q_mem[rd_ptr];
    assign id_inst = id_valid ? head.inst : '0;
    assign id_pc   = id_valid ? head.pc   : '0;

    always_ff @(posedge clk) begin
        if (rom_ce) begin
            q_mem[wr_ptr] <= '{inst: rom_inst, pc: pc};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc        <= RESET_PC;
            en_q      <= 1'b0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            fetch_cnt <= '0;
        end else begin
            en_q <= 1'b1;
            if (redirect) begin
                // Flush wins over any same-cycle pop; rom_ce is already low.
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
                pc     <= redirect_pc & ~ADDR_W'(7);
            end else begin
                if (rom_ce) begin
                    wr_ptr    <= wr_ptr + PTR_W'(1);
                    pc        <= pc + ADDR_W'(8);
                    fetch_cnt <= fetch_cnt + 32'd1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                case ({rom_ce, pop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: reset, streaming, backpressure, redirect, wrap, async reset.
module tb_inst_fetch;

    logic        clk;
    logic        rst;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [63:0] rom_inst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [63:0] id_inst;
    logic [31:0] id_pc;
    logic [31:0] fetch_cnt;

    int total = 0;
    int bad   = 0;

    inst_fetch #(
        .ADDR_W  (32),
        .INST_W  (64),
        .RESET_PC(32'h0),
        .DEPTH   (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rom_ce     (rom_ce),
        .rom_addr   (rom_addr),
        .rom_inst   (rom_inst),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .id_valid   (id_valid),
        .id_ready   (id_ready),
        .id_inst    (id_inst),
        .id_pc      (id_pc),
        .fetch_cnt  (fetch_cnt)
    );

    function automatic logic [63:0] rom_word(input logic [31:0] a);
        return {a ^ 32'hDEAD_BEEF, ~a};
    endfunction

    assign rom_inst = rom_word(rom_addr);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst         = 1'b0;
        id_ready    = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        #2;
        chk("rst_ce",    rom_ce,    0);
        chk("rst_vld",   id_valid,  0);
        chk("rst_inst",  id_inst,   0);
        chk("rst_pc",    id_pc,     0);
        chk("rst_cnt",   fetch_cnt, 0);
        chk("rst_addr",  rom_addr,  0);
        nxt();
        nxt();
        rst = 1'b1;
        #1;
        chk("c0_ce", rom_ce, 0);
        nxt(); #1;
        chk("c1_ce",   rom_ce,   1);
        chk("c1_addr", rom_addr, 32'h0);
        chk("c1_vld",  id_valid, 0);
        nxt(); #1;
        chk("c2_vld",  id_valid, 1);
        chk("c2_pc",   id_pc,    32'h0);
        chk("c2_inst", id_inst,  rom_word(32'h0));
        chk("c2_addr", rom_addr, 32'h8);
        nxt(); #1;
        chk("c3_pc",   id_pc,     32'h8);
        chk("c3_inst", id_inst,   rom_word(32'h8));
        chk("c3_cnt",  fetch_cnt, 2);
        nxt();
        // Async reset between edges, with decode stalled for the restart.
        chk("c4_pc", id_pc, 32'h10);
        id_ready = 1'b0;
        rst = 1'b0;
        #1;
        chk("ar_ce",   rom_ce,    0);
        chk("ar_vld",  id_valid,  0);
        chk("ar_cnt",  fetch_cnt, 0);
        chk("ar_addr", rom_addr,  0);
        nxt();
        rst = 1'b1;
        #1;
        chk("bp0_ce", rom_ce, 0);
        nxt(); #1;
        chk("bp1_ce",   rom_ce,   1);
        chk("bp1_addr", rom_addr, 32'h0);
        nxt(); #1;
        chk("bp2_ce",   rom_ce,   1);
        chk("bp2_addr", rom_addr, 32'h8);
        chk("bp2_pc",   id_pc,    32'h0);
        nxt(); #1;
        chk("bp3_ce",   rom_ce,    0);
        chk("bp3_addr", rom_addr,  32'h10);
        chk("bp3_pc",   id_pc,     32'h0);
        chk("bp3_inst", id_inst,   rom_word(32'h0));
        chk("bp3_cnt",  fetch_cnt, 2);
        nxt(); #1;
        chk("bp4_ce",   rom_ce,   0);
        chk("bp4_pc",   id_pc,    32'h0);
        chk("bp4_inst", id_inst,  rom_word(32'h0));
        id_ready = 1'b1;
        #1;
        chk("bp4_rdy_ce",   rom_ce,   1);
        chk("bp4_rdy_addr", rom_addr, 32'h10);
        nxt(); #1;
        chk("bp5_pc",   id_pc,    32'h8);
        chk("bp5_addr", rom_addr, 32'h18);
        nxt(); #1;
        chk("bp6_pc",  id_pc,     32'h10);
        chk("bp6_cnt", fetch_cnt, 4);
        // Queue holds 0x10 and 0x18; stall and redirect.
        id_ready = 1'b0;
        #1;
        chk("full_ce", rom_ce, 0);
        redirect    = 1'b1;
        redirect_pc = 32'h2B;
        #1;
        chk("rd_ce", rom_ce, 0);
        nxt();
        redirect = 1'b0;
        #1;
        chk("rd1_vld",  id_valid, 0);
        chk("rd1_addr", rom_addr, 32'h28);
        chk("rd1_ce",   rom_ce,   1);
        nxt(); #1;
        chk("rd2_vld",  id_valid, 1);
        chk("rd2_pc",   id_pc,    32'h28);
        chk("rd2_inst", id_inst,  rom_word(32'h28));
        nxt(); #1;
        chk("rd3_pc",  id_pc,     32'h28);
        chk("rd3_ce",  rom_ce,    0);
        chk("rd3_cnt", fetch_cnt, 6);
        // Redirect coinciding with a pop while full, targeting the wrap point.
        id_ready    = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        #1;
        chk("rp_ce", rom_ce, 0);
        nxt();
        redirect = 1'b0;
        #1;
        chk("rp1_vld",  id_valid,  0);
        chk("rp1_cnt",  fetch_cnt, 6);
        chk("rp1_addr", rom_addr,  32'hFFFF_FFF8);
        chk("rp1_ce",   rom_ce,    1);
        nxt(); #1;
        chk("wr1_pc",   id_pc,     32'hFFFF_FFF8);
        chk("wr1_inst", id_inst,   rom_word(32'hFFFF_FFF8));
        chk("wr1_addr", rom_addr,  32'h0);
        chk("wr1_cnt",  fetch_cnt, 7);
        nxt(); #1;
        chk("wr2_pc",   id_pc,     32'h0);
        chk("wr2_cnt",  fetch_cnt, 8);
        chk("wr2_addr", rom_addr,  32'h8);
        // Back-to-back redirects: the second target wins.
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        nxt();
        redirect_pc = 32'h207;
        #1;
        chk("bb1_ce",   rom_ce,   0);
        chk("bb1_vld",  id_valid, 0);
        chk("bb1_addr", rom_addr, 32'h100);
        nxt();
        redirect = 1'b0;
        #1;
        chk("bb2_addr", rom_addr,  32'h200);
        chk("bb2_vld",  id_valid,  0);
        chk("bb2_cnt",  fetch_cnt, 8);
        nxt(); #1;
        chk("bb3_pc",   id_pc,    32'h200);
        chk("bb3_inst", id_inst,  rom_word(32'h200));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        bad++;
        $display("FAIL timeout: simulation did not finish, got running want done");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Fetch-side initiator for the combinational 64-bit instruction ROM.
- Owns the PC and drives the ROM chip-enable and byte address.
- Captures the returned instruction word with its PC into a small prefetch queue.
- Presents queued words to decode over a valid/ready handshake; accepts branch redirects that flush the queue.

Parameters:
- ADDR_W, 32, PC and ROM byte-address width (matches InstAddrBus).
- INST_W, 64, instruction width (matches InstBus).
- RESET_PC, 0, PC loaded at reset; bits [2:0] must be zero.
- DEPTH, 2, prefetch queue entries; power of two, >=2.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- rom_ce  output  1  ROM chip enable; 1 = ChipEnable.
- rom_addr  output  ADDR_W  ROM byte address; always the current PC.
- rom_inst  input  INST_W  ROM data, valid combinationally in the same cycle as rom_ce/rom_addr.
- redirect  input  1  branch/jump taken; flush and reload PC.
- redirect_pc  input  ADDR_W  new fetch address; bits [2:0] ignored.
- id_valid  output  1  queue head holds a valid instruction.
- id_ready  input  1  decode accepts the head this cycle.
- id_inst  output  INST_W  head instruction; ZeroDoubleWord when id_valid=0.
- id_pc  output  ADDR_W  PC of head instruction; 0 when id_valid=0.
- fetch_cnt  output  32  number of ROM words pushed since reset; wraps.

Behaviour:
- Reset (rst=0, async):
  - pc=RESET_PC, queue empty (count=0, rd/wr pointers 0), fetch_cnt=0, en_q=0.
  - Outputs: rom_ce=0, id_valid=0, id_inst=0, id_pc=0.
- en_q is set to 1 on the first rising clk edge after rst deasserts, so rom_ce is low for exactly that first cycle.
- Signal definitions:
  - pop = id_valid & id_ready.
  - can_push = (count < DEPTH) | pop.
  - rom_ce = en_q & ~redirect & can_push (combinational).
  - rom_addr = pc at all times.
- Push: when rom_ce=1, write {rom_inst, pc} at the write pointer, then pc <= pc + 8, fetch_cnt <= fetch_cnt + 1.
- Pop: the read pointer advances. Same-cycle push and pop leave count unchanged.
- Latency: a word fetched in cycle N is visible on id_valid/id_inst/id_pc in cycle N+1 (queue storage is registered). No combinational path from rom_inst to id_*.
- id_inst and id_pc are held stable while id_valid=1 and id_ready=0.
- Full: count==DEPTH with no pop gives rom_ce=0; PC and the queue hold.
- Redirect:
  - Has priority over push and pop in the same cycle.
  - Queue is emptied (count=0, pointers reset), pc <= {redirect_pc[ADDR_W-1:3], 3'b000}, rom_ce=0, no push.
  - id_valid=0 in the following cycle; the first target word is fetched that cycle and presented the cycle after.
  - A pop coinciding with redirect still counts as accepted by decode, but the queue is cleared regardless.
- PC wrap-around: pc = 2^ADDR_W - 8 increments to 0 with no flag.
- Back-to-back redirects: each one reloads the PC; the last one wins.
- Reset mid-operation: immediate return to reset state; queue contents discarded.
- Steady-state throughput: 1 instruction/cycle while id_ready=1.

Test Plan:
- Reset release, id_ready=1:
  - cycle 0 after release: rom_ce=0.
  - cycle 1: rom_ce=1, rom_addr=0x0.
  - cycle 2: id_valid=1, id_pc=0x0, id_inst=ROM[0]; rom_addr=0x8.
  - Then id_pc=0x8, 0x10, ... on consecutive cycles.
- Backpressure, DEPTH=2, id_ready=0 from reset:
  - Two pushes (pc 0x0, 0x8), then rom_ce=0 and rom_addr holds 0x10.
  - id_pc stays 0x0 and id_inst stays ROM[0].
  - On id_ready=1, the same cycle shows rom_ce=1 at 0x10; no word is lost or duplicated.
- Redirect to 0x2B while the queue holds 2 entries:
  - Next cycle: id_valid=0, rom_addr=0x28, rom_ce=1.
  - Cycle after: id_pc=0x28; the two old words are never presented.
- Redirect and pop in the same cycle while full: queue empties, no push that cycle, fetch_cnt unchanged that cycle.
- Wrap: redirect to 0xFFFFFFF8, id_ready=1 -> pushes at 0xFFFFFFF8 then 0x0; id_pc sequence 0xFFFFFFF8, 0x0; fetch_cnt increments by 2.
- Async reset asserted mid-stream between clock edges -> rom_ce=0, id_valid=0, fetch_cnt=0 immediately (before the next edge); restart fetches from RESET_PC.
